pipe_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage Y86-64 core: drives stall/bubble inputs of the
//  F/D/E/M/W pipe registers (F_stall/F_bubble, D_*, E_*, M_*, W_*) and the CC write enable.

---
 rtl/y86_pkg.sv | 37 +++
 rtl/pipe_perf_cnt.sv | 27 ++
 rtl/pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the bundle of pipe-register control bits
// produced by the pipeline control unit.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic f_stall;
    logic f_bubble;
    logic d_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic w_stall;
    logic w_bubble;
    logic set_cc;
  } pipe_ctl_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// One performance counter: counts enabled cycles, wraps modulo 2^CNT_W,
// cleared by the synchronous reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard detection driving the F/D/E/M/W pipe
// register stall/bubble inputs, sticky halt, dmem watchdog and perf counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WDOG_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             imem_busy_i,
  input  logic             dmem_busy_i,
  output logic             F_stall_o,
  output logic             F_bubble_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             W_bubble_o,
  output logic             set_cc_o,
  output logic             halted_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bub_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [15:0] WDOG_LIM = 16'(WDOG_MAX);

  logic        lu, ret, mp, exm, exw, any_term;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;
  logic [15:0] wdog_q, wdog_d;
  logic        wdog_trip;
  pipe_ctl_t   ctl;

  always_comb begin
    lu = (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && (E_dstM_i != RNONE) &&
         (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    ret = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    mp  = (E_icode_i == IJXX) && !e_Cnd_i;
    exm = (m_stat_i != SAOK);
    exw = (W_stat_i != SAOK);
    any_term = lu | ret | mp | exm | exw;
  end

  // Reset, then a frozen core, then a dmem wait-state, then hazards. An imem
  // miss only matters when no hazard already holds fetch; the E-stage
  // instruction still proceeds then, so set_cc stays live.
  always_comb begin
    ctl = '0;
    if (rst_i) begin
      ctl.f_bubble = 1'b1;
      ctl.d_bubble = 1'b1;
      ctl.e_bubble = 1'b1;
      ctl.m_bubble = 1'b1;
      ctl.w_bubble = 1'b1;
    end else if (halted_q) begin
      ctl.f_stall = 1'b1;
      ctl.d_stall = 1'b1;
      ctl.w_stall = 1'b1;
    end else if (dmem_busy_i) begin
      ctl.f_stall  = 1'b1;
      ctl.d_stall  = 1'b1;
      ctl.w_stall  = 1'b1;
      ctl.w_bubble = 1'b1;
    end else begin
      ctl.f_stall  = lu | ret;
      ctl.d_stall  = lu;
      ctl.d_bubble = mp | (ret & !lu);
      ctl.e_bubble = mp | lu;
      ctl.m_bubble = exm | exw;
      ctl.w_stall  = exw;
      ctl.set_cc   = (E_icode_i == IOPQ) && !exm && !exw;
      if (imem_busy_i && !any_term) begin
        ctl.f_stall  = 1'b1;
        ctl.d_bubble = 1'b1;
      end
    end
  end

  // Watchdog counts consecutive busy cycles and saturates rather than wrapping.
  always_comb begin
    wdog_trip = dmem_busy_i && !halted_q && (wdog_q >= WDOG_LIM);
    wdog_d    = wdog_q;
    if (!dmem_busy_i)                        wdog_d = '0;
    else if (!halted_q && wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
    halted_d  = halted_q | exw | wdog_trip;
    timeout_d = timeout_q | wdog_trip;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  logic cyc_en, stall_en, bub_en, mis_en;

  always_comb begin
    cyc_en   = !halted_q;
    stall_en = !halted_q && ctl.f_stall;
    bub_en   = !halted_q && (ctl.d_bubble | ctl.e_bubble | ctl.m_bubble);
    mis_en   = !halted_q && !dmem_busy_i && mp;
  end

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(cyc_en), .cnt_o(cyc_cnt_o)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(stall_en), .cnt_o(stall_cnt_o)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bub_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(bub_en), .cnt_o(bub_cnt_o)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(mis_en), .cnt_o(mispred_cnt_o)
  );

  assign F_stall_o  = ctl.f_stall;
  assign F_bubble_o = ctl.f_bubble;
  assign D_stall_o  = ctl.d_stall;
  assign D_bubble_o = ctl.d_bubble;
  assign E_bubble_o = ctl.e_bubble;
  assign M_bubble_o = ctl.m_bubble;
  assign W_stall_o  = ctl.w_stall;
  assign W_bubble_o = ctl.w_bubble;
  assign set_cc_o   = ctl.set_cc;
  assign halted_o   = halted_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard/halt/watchdog scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CW = 8;
  localparam int WD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic          e_Cnd;
  logic [2:0]    m_stat, W_stat;
  logic          imem_busy, dmem_busy;
  logic          F_stall, F_bubble, D_stall, D_bubble, E_bubble, M_bubble;
  logic          W_stall, W_bubble, set_cc, halted, timeout;
  logic [CW-1:0] cyc_cnt, stall_cnt, bub_cnt, mis_cnt;

  pipe_ctrl #(.CNT_W(CW), .WDOG_MAX(WD)) dut (
    .clk_i(clk), .rst_i(rst),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .imem_busy_i(imem_busy), .dmem_busy_i(dmem_busy),
    .F_stall_o(F_stall), .F_bubble_o(F_bubble), .D_stall_o(D_stall),
    .D_bubble_o(D_bubble), .E_bubble_o(E_bubble), .M_bubble_o(M_bubble),
    .W_stall_o(W_stall), .W_bubble_o(W_bubble), .set_cc_o(set_cc),
    .halted_o(halted), .timeout_o(timeout),
    .cyc_cnt_o(cyc_cnt), .stall_cnt_o(stall_cnt), .bub_cnt_o(bub_cnt),
    .mispred_cnt_o(mis_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, always holding what the DUT state should be now.
  bit m_halted = 0, m_timeout = 0;
  int m_wdog = 0, m_cyc = 0, m_stall = 0, m_bub = 0, m_mis = 0;

  always @(negedge clk) begin : compare
    bit lu, ret, mp, exm, exw, trip;
    bit fs, fb, ds, db, eb, mb, ws, wb, cc;
    lu  = (E_icode == IMRMOVQ || E_icode == IPOPQ) && E_dstM != RNONE &&
          (E_dstM == d_srcA || E_dstM == d_srcB);
    ret = D_icode == IRET || E_icode == IRET || M_icode == IRET;
    mp  = E_icode == IJXX && !e_Cnd;
    exm = m_stat != SAOK;
    exw = W_stat != SAOK;
    {fs, fb, ds, db, eb, mb, ws, wb, cc} = '0;
    if (rst) {fb, db, eb, mb, wb} = 5'b11111;
    else if (m_halted) {fs, ds, ws} = 3'b111;
    else if (dmem_busy) {fs, ds, ws, wb} = 4'b1111;
    else if (lu || ret || mp || exm || exw) begin
      fs = lu | ret;
      ds = lu;
      db = mp | (ret & !lu);
      eb = mp | lu;
      mb = exm | exw;
      ws = exw;
      cc = E_icode == IOPQ && !exm && !exw;
    end else begin
      cc = E_icode == IOPQ;
      fs = imem_busy;
      db = imem_busy;
    end
    check("F_stall", F_stall, fs);
    check("F_bubble", F_bubble, fb);
    check("D_stall", D_stall, ds);
    check("D_bubble", D_bubble, db);
    check("E_bubble", E_bubble, eb);
    check("M_bubble", M_bubble, mb);
    check("W_stall", W_stall, ws);
    check("W_bubble", W_bubble, wb);
    check("set_cc", set_cc, cc);
    check("halted", halted, m_halted);
    check("timeout", timeout, m_timeout);
    check("cyc_cnt", cyc_cnt, m_cyc);
    check("stall_cnt", stall_cnt, m_stall);
    check("bub_cnt", bub_cnt, m_bub);
    check("mispred_cnt", mis_cnt, m_mis);
    // advance the model to the state after the coming posedge
    if (rst) begin
      m_halted = 0; m_timeout = 0; m_wdog = 0;
      m_cyc = 0; m_stall = 0; m_bub = 0; m_mis = 0;
    end else begin
      trip = dmem_busy && !m_halted && m_wdog >= WD;
      if (!m_halted) begin
        m_cyc = (m_cyc + 1) % (1 << CW);
        if (fs) m_stall = (m_stall + 1) % (1 << CW);
        if (db || eb || mb) m_bub = (m_bub + 1) % (1 << CW);
        if (mp && !dmem_busy) m_mis = (m_mis + 1) % (1 << CW);
      end
      if (!dmem_busy) m_wdog = 0;
      else if (!m_halted && m_wdog < 65535) m_wdog++;
      if (trip) m_timeout = 1;
      if (exw || trip) m_halted = 1;
    end
  end

  // driver tasks
  task automatic idle_inputs();
    D_icode = INOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = INOP; E_dstM = RNONE; e_Cnd = 1'b0; M_icode = INOP;
    m_stat = SAOK; W_stat = SAOK; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // bit order: F_stall F_bubble D_stall D_bubble E_bubble M_bubble W_stall W_bubble set_cc
  task automatic chk_ctl(input string name, input logic [8:0] exp);
    check(name, {F_stall, F_bubble, D_stall, D_bubble, E_bubble, M_bubble,
                 W_stall, W_bubble, set_cc}, exp);
  endtask

  task automatic chk_cnt(input string name, input int c, input int s, input int b, input int m);
    check({name, "_cyc"}, cyc_cnt, c);
    check({name, "_stall"}, stall_cnt, s);
    check({name, "_bub"}, bub_cnt, b);
    check({name, "_mis"}, mis_cnt, m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1 chk_ctl("reset_ctl", 9'b010111010);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    check("reset_halted", halted, 0);
    check("reset_timeout", timeout, 0);
    chk_cnt("reset", 0, 0, 0, 0);
  endtask

  task automatic rand_inputs(input int seg);
    D_icode = 4'($urandom_range(0, 11));
    E_icode = 4'($urandom_range(0, 11));
    M_icode = 4'($urandom_range(0, 11));
    d_srcA  = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
    d_srcB  = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
    E_dstM  = ($urandom_range(0, 4) == 0) ? RNONE : 4'($urandom_range(0, 3));
    e_Cnd   = 1'($urandom_range(0, 1));
    m_stat  = ($urandom_range(0, 19) == 0) ? SADR : SAOK;
    W_stat  = (seg != 0 && $urandom_range(0, 99) == 0) ? SHLT : SAOK;
    imem_busy = ($urandom_range(0, 3) == 0);
    dmem_busy = (seg == 3) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 6) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // idle, load-use, mispredict, ret x3, OPq
    #1 chk_ctl("idle", 9'b000000000);
    next_cycle();
    E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3; D_icode = IOPQ;
    #1 chk_ctl("load_use", 9'b101010000);
    next_cycle();
    chk_cnt("after_lu", 2, 1, 1, 0);
    E_icode = IJXX; E_dstM = RNONE; d_srcA = RNONE; e_Cnd = 1'b0; D_icode = IRET;
    #1 chk_ctl("mispred", 9'b100110000);
    next_cycle();
    E_icode = INOP;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl("ret", 9'b100100000);
      next_cycle();
    end
    D_icode = INOP; E_icode = IOPQ;
    #1 chk_ctl("opq", 9'b000000001);
    next_cycle();
    chk_cnt("after_ret", 7, 5, 5, 1);
    E_icode = INOP; imem_busy = 1'b1;
    #1 chk_ctl("imem_busy", 9'b100100000);
    next_cycle();
    imem_busy = 1'b0; W_stat = SHLT;
    #1 chk_ctl("exw", 9'b000001100);
    check("halted_pre", halted, 0);
    next_cycle();
    check("halted_post", halted, 1);
    W_stat = SAOK;
    #1 chk_ctl("halted_ctl", 9'b101000100);
    chk_cnt("halt", 9, 6, 7, 1);
    next_cycle();
    chk_cnt("halt_hold", 9, 6, 7, 1);

    // watchdog: trips after the fifth consecutive busy edge
    do_reset();
    dmem_busy = 1'b1;
    #1 chk_ctl("dmem_busy", 9'b101000110);
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      if (i == 4) check("wdog_pre", timeout, 0);
      if (i == 5) begin
        check("wdog_timeout", timeout, 1);
        check("wdog_halted", halted, 1);
      end
    end
    idle_inputs();

    // exW together with dmem_busy: halt, no timeout
    do_reset();
    dmem_busy = 1'b1; W_stat = SADR;
    #1 chk_ctl("busy_exw", 9'b101000110);
    next_cycle();
    check("busy_exw_halted", halted, 1);
    check("busy_exw_timeout", timeout, 0);
    idle_inputs();

    // reset in the middle of a dmem stall clears the watchdog too
    do_reset();
    dmem_busy = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1 chk_ctl("rst_busy", 9'b010111010);
    next_cycle();
    rst = 1'b0;
    chk_cnt("rst_busy", 0, 0, 0, 0);
    check("rst_busy_halted", halted, 0);
    for (int i = 0; i < 4; i++) next_cycle();
    check("rst_busy_wdog", timeout, 0);
    idle_inputs();

    // randomized traffic, checked by the compare process
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int n = 0; n < 320; n++) begin
        rand_inputs(seg);
        next_cycle();
      end
    end
    idle_inputs();
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
